// File: rtl/uart_tx_mmio_if.sv
`default_nettype none
// ============================================================================
// uart_tx_mmio_if : single-cycle peripheral bus port of the console UART
// Revision 1.0
// ============================================================================
interface uart_tx_mmio_if;
    logic        en_i;
    logic [3:0]  we_i;
    logic [3:0]  addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (output en_i, we_i, addr_i, data_i, input data_o);
    modport slave  (input en_i, we_i, addr_i, data_i, output data_o);
endinterface
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// uart_tx_mmio : memory-mapped 8N1 UART transmitter with TX FIFO and TX-empty irq
// Revision 1.0
// ============================================================================
module uart_tx_mmio #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd867
) (
    input  logic          clk,
    input  logic          reset_n,
    uart_tx_mmio_if.slave bus,
    output logic          tx_o,
    output logic          irq_o
);
    localparam int unsigned c_AW      = $clog2(FIFO_DEPTH);
    localparam logic [1:0]  c_IDLE    = 2'd0;
    localparam logic [1:0]  c_START   = 2'd1;
    localparam logic [1:0]  c_DATA    = 2'd2;
    localparam logic [1:0]  c_STOP    = 2'd3;
    localparam logic [3:0]  c_A_TXD   = 4'h0;
    localparam logic [3:0]  c_A_STAT  = 4'h4;
    localparam logic [3:0]  c_A_BAUD  = 4'h8;
    localparam logic [3:0]  c_A_CTRL  = 4'hC;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [c_AW:0] wr_q, rd_q, w_level;
    logic          w_empty, w_full, w_wr, w_rd, w_push, w_pop, w_tick;
    logic [1:0]    state_q, state_d;
    logic [15:0]   cnt_q, cnt_d, fdiv_q, fdiv_d, baud_q;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_q, bit_d;
    logic          tx_q, tx_d, irqen_q, irq_q, irq_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          w_unused;

    assign w_level = wr_q - rd_q;
    assign w_empty = (w_level == '0);
    // Level never exceeds FIFO_DEPTH, so its MSB alone marks "full".
    assign w_full  = w_level[c_AW];
    assign w_wr    = bus.en_i & (|bus.we_i);
    assign w_rd    = bus.en_i & ~(|bus.we_i);
    assign w_push  = w_wr & (bus.addr_i == c_A_TXD) & (~w_full | w_pop);
    assign w_tick  = (cnt_q == 16'd0);
    assign w_unused = ^bus.data_i[31:16];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= c_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (!w_empty) state_d = c_START;
            c_START: if (w_tick) state_d = c_DATA;
            c_DATA:  if (w_tick && bit_q == 3'd7) state_d = c_STOP;
            c_STOP:  if (w_tick) state_d = w_empty ? c_IDLE : c_START;
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        w_pop   = 1'b0;
        cnt_d   = cnt_q;
        fdiv_d  = fdiv_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        case (state_q)
            c_IDLE:  w_pop = ~w_empty;
            c_START: begin
                if (w_tick) begin
                    tx_d  = shift_q[0];
                    bit_d = 3'd0;
                    cnt_d = fdiv_q;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            c_DATA: begin
                if (w_tick) begin
                    cnt_d = fdiv_q;
                    if (bit_q == 3'd7) begin
                        tx_d = 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            c_STOP: begin
                if (w_tick) w_pop = ~w_empty;
                else        cnt_d = cnt_q - 16'd1;
            end
            default: ;
        endcase
        // Loading a new frame latches the divisor so mid-frame writes wait a frame.
        if (w_pop) begin
            shift_d = mem_q[rd_q[c_AW-1:0]];
            fdiv_d  = baud_q;
            cnt_d   = baud_q;
            tx_d    = 1'b0;
        end
    end

    assign irq_d = irqen_q & w_empty & (state_q == c_IDLE);

    always_comb begin
        rdata_d = rdata_q;
        if (w_rd) begin
            case (bus.addr_i)
                c_A_STAT: rdata_d = {16'd0, 8'(w_level), 5'd0, (state_q != c_IDLE), w_full, w_empty};
                c_A_BAUD: rdata_d = {16'd0, baud_q};
                c_A_CTRL: rdata_d = {31'd0, irqen_q};
                default:  rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= 16'd0;
            fdiv_q  <= 16'd0;
            shift_q <= 8'd0;
            bit_q   <= 3'd0;
            tx_q    <= 1'b1;
            baud_q  <= DIV_RESET;
            irqen_q <= 1'b0;
            irq_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            if (w_push) wr_q <= wr_q + 1'b1;
            if (w_pop)  rd_q <= rd_q + 1'b1;
            cnt_q   <= cnt_d;
            fdiv_q  <= fdiv_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            irq_q   <= irq_d;
            rdata_q <= rdata_d;
            if (w_wr && bus.addr_i == c_A_BAUD) baud_q  <= bus.data_i[15:0];
            if (w_wr && bus.addr_i == c_A_CTRL) irqen_q <= bus.data_i[0];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_q[c_AW-1:0]] <= bus.data_i[7:0];
    end

    assign bus.data_o = rdata_q;
    assign tx_o       = tx_q;
    assign irq_o      = irq_q;
endmodule
`default_nettype wire
